// File: rtl/mac_r_drain_arb.sv
// Per-port rx readout arbiter: grants staging-RAM read port/CRC to the BE or TTE drain engine per frame.
// Start 1 cycle after class pulse, idle 1 cycle after done; back-pressured classes are dropped, hung drains aborted.
module mac_r_drain_arb #(
    parameter int MTU        = 1500,
    parameter int WDOG_SLACK = 64,
    parameter int CNT_W      = 16
) (
    input  logic             rx_clk,
    input  logic             rstn_mac,
    input  logic [1:0]       speed,
    input  logic             load_be,
    input  logic             load_tte,
    input  logic             load_req,
    input  logic [12:0]      load_byte,
    input  logic             bp_be,
    input  logic             bp_tte,
    input  logic             done_be,
    input  logic             done_tte,
    output logic             start_be,
    output logic             start_tte,
    output logic             abort,
    output logic [1:0]       rd_sel,
    output logic [12:0]      frame_len,
    output logic             busy,
    output logic [CNT_W-1:0] drop_be_cnt,
    output logic [CNT_W-1:0] drop_tte_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DROP} state_t;

    localparam logic [13:0] FRAME_MAX = 14'(MTU + 18);

    state_t           state_q, state_d;
    logic [1:0]       rd_sel_q, rd_sel_d;
    logic             start_be_q, start_be_d, start_tte_q, start_tte_d;
    logic             abort_q, abort_d;
    logic [12:0]      frame_len_q, frame_len_d;
    logic [13:0]      wdog_q, wdog_d;
    logic [CNT_W-1:0] drop_be_cnt_q, drop_be_cnt_d;
    logic [CNT_W-1:0] drop_tte_cnt_q, drop_tte_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             drop_be_inc, drop_tte_inc, err_inc;
    logic             owner_done;
    logic [13:0]      len_eff, len_x, limit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // Oversized lengths are clamped so the 14-bit limit can never wrap.
    always_comb begin
        len_eff = ({1'b0, frame_len_q} > FRAME_MAX) ? FRAME_MAX : {1'b0, frame_len_q};
        len_x   = speed[1] ? len_eff : {len_eff[12:0], 1'b0};
        limit   = len_x + 14'(WDOG_SLACK);
    end

    assign owner_done = ((rd_sel_q == 2'b01) && done_be) || ((rd_sel_q == 2'b10) && done_tte);

    always_comb begin
        state_d      = state_q;
        rd_sel_d     = rd_sel_q;
        start_be_d   = 1'b0;
        start_tte_d  = 1'b0;
        abort_d      = 1'b0;
        frame_len_d  = frame_len_q;
        wdog_d       = wdog_q;
        drop_be_inc  = 1'b0;
        drop_tte_inc = 1'b0;
        err_inc      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_tte) begin
                    err_inc = load_be;
                    if (bp_tte) begin
                        drop_tte_inc = 1'b1;
                        state_d      = DROP;
                    end else begin
                        start_tte_d = 1'b1;
                        rd_sel_d    = 2'b10;
                        state_d     = ACTIVE;
                    end
                end else if (load_be) begin
                    if (bp_be) begin
                        drop_be_inc = 1'b1;
                        state_d     = DROP;
                    end else begin
                        start_be_d = 1'b1;
                        rd_sel_d   = 2'b01;
                        state_d    = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (load_req) begin
                    frame_len_d = load_byte;
                    wdog_d      = '0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                wdog_d = wdog_q + 14'd1;
                // A done landing on the limit cycle takes priority over the abort.
                if (owner_done) begin
                    rd_sel_d = 2'b00;
                    state_d  = IDLE;
                end else if (wdog_d >= limit) begin
                    abort_d  = 1'b1;
                    rd_sel_d = 2'b00;
                    err_inc  = 1'b1;
                    state_d  = IDLE;
                end
            end
            DROP: begin
                if (load_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && (load_be || load_tte)) err_inc = 1'b1;
        drop_be_cnt_d  = sat_inc(drop_be_cnt_q, drop_be_inc);
        drop_tte_cnt_d = sat_inc(drop_tte_cnt_q, drop_tte_inc);
        err_cnt_d      = sat_inc(err_cnt_q, err_inc);
    end

    always_ff @(posedge rx_clk or negedge rstn_mac) begin
        if (!rstn_mac) begin
            state_q        <= IDLE;
            rd_sel_q       <= 2'b00;
            start_be_q     <= 1'b0;
            start_tte_q    <= 1'b0;
            abort_q        <= 1'b0;
            frame_len_q    <= '0;
            wdog_q         <= '0;
            drop_be_cnt_q  <= '0;
            drop_tte_cnt_q <= '0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            rd_sel_q       <= rd_sel_d;
            start_be_q     <= start_be_d;
            start_tte_q    <= start_tte_d;
            abort_q        <= abort_d;
            frame_len_q    <= frame_len_d;
            wdog_q         <= wdog_d;
            drop_be_cnt_q  <= drop_be_cnt_d;
            drop_tte_cnt_q <= drop_tte_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign start_be     = start_be_q;
    assign start_tte    = start_tte_q;
    assign abort        = abort_q;
    assign rd_sel       = rd_sel_q;
    assign frame_len    = frame_len_q;
    assign busy         = (state_q != IDLE);
    assign drop_be_cnt  = drop_be_cnt_q;
    assign drop_tte_cnt = drop_tte_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule
